// File: rtl/ge_pkg.sv
// Shared types and constants for the stage sequencer.
// Optional retry support is selected elsewhere by the STAGE_SEQ_RETRY_EN macro.
package ge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROLL,
        ST_EVAL,
        ST_SCORE,
        ST_DONE
    } state_t;

    // A zero seed would lock the LFSR at zero, so it is replaced on load.
    localparam logic [6:0] LFSR_ZERO_SUB = 7'h5A;
    localparam logic [5:0] SCORE_MAX     = 6'd63;

    // Adds bonus+1 to the score, clamping at SCORE_MAX.
    function automatic logic [5:0] score_add(input logic [5:0] score, input logic [1:0] bonus);
        logic [6:0] sum;
        sum = {1'b0, score} + {5'b0, bonus} + 7'd1;
        if (sum > {1'b0, SCORE_MAX}) begin
            return SCORE_MAX;
        end
        return sum[5:0];
    endfunction

endpackage

// File: rtl/ge_lfsr7.sv
// 7-bit Fibonacci LFSR used to generate the per-stage random vector.
// Loading a zero seed substitutes LFSR_ZERO_SUB so the register never sits at zero.
module ge_lfsr7
    import ge_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    input  logic [6:0] seed,
    output logic [6:0] q
);

    logic [6:0] q_q;
    logic [6:0] q_d;

    // Next-value selection: load has priority over step.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (seed == 7'd0) ? LFSR_ZERO_SUB : seed;
        end else if (step) begin
            q_d = {q_q[5:0], q_q[6] ^ q_q[5]};
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 7'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/stage_seq.sv
// Stage sequencer: runs NUM_STAGES roll/evaluate/score rounds per game.
// Define STAGE_SEQ_RETRY_EN to let a failed stage be retried while lives remain.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | waiting for start; results of last game held
// ROLL     | advance LFSR to produce the stage's random vector
// EVAL     | stg_eval high; stage result captured at cycle end
// SCORE    | apply captured result, pick next stage/retry/finish
// DONE     | game over; done pulses as we return to IDLE
module stage_seq
    import ge_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int INIT_LIVES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] seed,
    input  logic       stg_pass,
    input  logic [1:0] stg_bonus,
    output logic [6:0] rnd,
    output logic [3:0] stg_idx,
    output logic       stg_eval,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic [5:0] score,
    output logic [1:0] lives
);

    localparam logic [3:0] LAST_IDX  = 4'(NUM_STAGES - 1);
    localparam logic [1:0] LIVES_RST = 2'(INIT_LIVES);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       eval_q, eval_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       win_q, win_d;
    logic [5:0] score_q, score_d;
    logic [1:0] lives_q, lives_d;
    logic       pass_q, pass_d;
    logic [1:0] bonus_q, bonus_d;
    logic       lfsr_load;
    logic       lfsr_step;

    ge_lfsr7 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (seed),
        .q     (rnd)
    );

    // Next-state and next-output logic; outputs are registered so each reflects the state entered.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        eval_d    = 1'b0;
        done_d    = 1'b0;
        win_d     = win_q;
        score_d   = score_q;
        lives_d   = lives_q;
        pass_d    = pass_q;
        bonus_d   = bonus_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    score_d   = 6'd0;
                    win_d     = 1'b0;
                    idx_d     = 4'd0;
                    lives_d   = LIVES_RST;
                    state_d   = ST_ROLL;
                end
            end
            ST_ROLL: begin
                lfsr_step = 1'b1;
                eval_d    = 1'b1;
                state_d   = ST_EVAL;
            end
            ST_EVAL: begin
                pass_d  = stg_pass;
                bonus_d = stg_bonus;
                state_d = ST_SCORE;
            end
            ST_SCORE: begin
                if (pass_q) begin
                    score_d = score_add(score_q, bonus_q);
                    if (idx_q == LAST_IDX) begin
                        win_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_ROLL;
                    end
                end else begin
`ifdef STAGE_SEQ_RETRY_EN
                    if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                        state_d = ST_ROLL;
                    end else begin
                        win_d   = 1'b0;
                        state_d = ST_DONE;
                    end
`else
                    win_d   = 1'b0;
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            eval_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= 1'b0;
            score_q <= 6'd0;
            lives_q <= 2'd0;
            pass_q  <= 1'b0;
            bonus_q <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            eval_q  <= eval_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            win_q   <= win_d;
            score_q <= score_d;
            lives_q <= lives_d;
            pass_q  <= pass_d;
            bonus_q <= bonus_d;
        end
    end

    assign stg_idx  = idx_q;
    assign stg_eval = eval_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign win      = win_q;
    assign score    = score_q;
    assign lives    = lives_q;

endmodule
